checker_sched: RTL and testbench
================================

// Module: checker_sched
// PURPOSE
//  Round-robin scheduler in front of the checker_single bank. Up to NREQ requesters
//  post (mode, addr) check jobs. The scheduler grants one job at a time, drives the
//  shared cmode/cstart/caddr bus, waits for cend and returns cctrl to the granted requester.
//  Only one checker run is in flight at any time. The checker mode select is time-shared.
// PARAMETERS
//  ID_W            2      requester index width; NREQ = 1<<ID_W requesters
//  TIMEOUT_CYCLES  1024   RUN-state watchdog limit (used only with CHECKER_SCHED_TIMEOUT_EN)
//  TO_W            16     watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  sys_clk      in   1          system clock; all logic on posedge
//  sys_rst      in   1          synchronous, active-high reset
//  req_valid    in   NREQ       per-requester job pending; held until its req_ack bit pulses
//  req_mode     in   2*NREQ     requester i mode at [2i+1:2i]
//  req_addr     in   64*NREQ    requester i address at [64i+63:64i]
//  req_ack      out  NREQ       one-hot, 1-cycle grant pulse
//  rsp_valid    out  1          1-cycle completion pulse
//  rsp_id       out  ID_W       requester index of completed job; valid with rsp_valid
//  rsp_ctrl     out  8          checker cctrl captured at cend (8'hFF on timeout)
//  rsp_timeout  out  1          job ended by watchdog; valid with rsp_valid
//  busy         out  1          high in RUN and DONE
//  cmode        out  2          mode to checker bank
//  caddr        out  64         address to checker bank
//  cstart       out  1          level start to checker bank; high throughout RUN
//  cend         in   1          checker completion pulse
//  cctrl        in   8          checker status; sampled when cend=1
// BEHAVIOUR
//  - Reset: state=IDLE; rr_ptr=0; req_ack, rsp_valid, rsp_id, rsp_ctrl, rsp_timeout, busy,
//    cmode, caddr, cstart all 0. Reset mid-job drops the job. No rsp is issued for it.
//  - FSM IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//  - IDLE: if req_valid!=0 at edge N, pick the first set bit starting at rr_ptr, scanning
//    upward with wrap. Edge N registers winner w, cmode=req_mode[w], caddr=req_addr[w],
//    cstart=1, req_ack[w]=1 for that cycle only, rr_ptr=(w+1) mod NREQ, state=RUN.
//    Grant latency: 1 cycle from req_valid to cstart/req_ack.
//  - req_valid dropped before grant: the job is withdrawn. No ack, no rsp.
//  - RUN: cmode/caddr are held stable. On cend=1 at an edge: cstart=0, rsp_valid=1,
//    rsp_id=w, rsp_ctrl=cctrl, rsp_timeout=0, state=DONE.
//  - DONE: exactly one cycle with cstart low, so the checker sees the start drop. Then IDLE.
//    Back-to-back jobs: cstart is high at most every 3rd cycle minimum spacing.
//  - cend outside RUN (including the grant cycle's edge and DONE) is ignored.
//  - rsp_* hold their values after the pulse until the next completion; only rsp_valid pulses.
//  - New req_valid during RUN/DONE waits. It is arbitrated in IDLE using the updated rr_ptr.
//  - Single requester asserted continuously: granted every job, no starvation logic needed.
// CONFIGURATION
//  CHECKER_SCHED_TIMEOUT_EN defined:
//  - A TO_W-bit counter clears on entry to RUN and increments each RUN cycle without cend.
//  - When the counter reaches TIMEOUT_CYCLES-1 without cend, next edge: cstart=0,
//    rsp_valid=1, rsp_timeout=1, rsp_ctrl=8'hFF, state=DONE.
//  - cend on the same edge as expiry wins: normal completion, rsp_timeout=0.
//  CHECKER_SCHED_TIMEOUT_EN undefined:
//  - No counter is instantiated. RUN waits indefinitely for cend. rsp_timeout is tied 0.
// TESTING
//  1 Reset, req_valid=4'b0001, mode0=2'd2, addr0=64'h1000; cend with cctrl=8'h5A 4 cycles later
//    -> req_ack=0001 and cstart=1 one cycle after req, cmode=2, caddr=h1000;
//    rsp_valid pulse, rsp_id=0, rsp_ctrl=h5A; cstart low one cycle, then IDLE.
//  2 req_valid=4'b1111 held, each job ends with cend after 2 cycles
//    -> grant order 0,1,2,3,0; exactly one ack per job; no overlap of cstart runs.
//  3 rr_ptr=2, req_valid=4'b0011 -> grant 0 (wrap), rr_ptr becomes 1.
//  4 cend pulsed while IDLE and during DONE -> no rsp_valid, state unchanged.
//  5 sys_rst asserted mid-RUN -> next cycle all outputs 0, IDLE; late cend ignored; no rsp.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=8, no cend -> rsp_valid with rsp_timeout=1, rsp_ctrl=hFF
//    8 cycles after cstart rise; repeat with cend on the expiry edge -> rsp_timeout=0.

Source files
------------

// File: rtl/checker_sched.sv
// Round-robin job scheduler that time-shares one checker bank among 1<<ID_W requesters.
// Optional RUN-state watchdog enabled by defining CHECKER_SCHED_TIMEOUT_EN.
module checker_sched #(
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [(1<<ID_W)-1:0]        req_valid,
    input  logic [2*(1<<ID_W)-1:0]      req_mode,
    input  logic [64*(1<<ID_W)-1:0]     req_addr,
    output logic [(1<<ID_W)-1:0]        req_ack,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [7:0]                  rsp_ctrl,
    output logic                        rsp_timeout,
    output logic                        busy,
    output logic [1:0]                  cmode,
    output logic [63:0]                 caddr,
    output logic                        cstart,
    input  logic                        cend,
    input  logic [7:0]                  cctrl
);

    localparam int unsigned NREQ = 1 << ID_W;

    // Watchdog must be able to count up to TIMEOUT_CYCLES-1.
    if (TO_W == 0 || TIMEOUT_CYCLES == 0 || $clog2(TIMEOUT_CYCLES) > TO_W) begin : g_cfg_err
        $error("checker_sched: TO_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NREQ-1:0]   req_ack_q, req_ack_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_ctrl_q, rsp_ctrl_d;
    logic              busy_q, busy_d;
    logic [1:0]        cmode_q, cmode_d;
    logic [63:0]       caddr_q, caddr_d;
    logic              cstart_q, cstart_d;
`ifdef CHECKER_SCHED_TIMEOUT_EN
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;
`endif

    logic              found_c;
    logic [ID_W-1:0]   win_c;
    logic [ID_W-1:0]   scan_idx_c;
    logic [1:0]        sel_mode_c;
    logic [63:0]       sel_addr_c;

    // Round-robin pick: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        found_c    = 1'b0;
        win_c      = '0;
        scan_idx_c = '0;
        sel_mode_c = '0;
        sel_addr_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx_c = rr_ptr_q + ID_W'(k);
            if (!found_c && req_valid[scan_idx_c]) begin
                found_c = 1'b1;
                win_c   = scan_idx_c;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c == ID_W'(i)) begin
                sel_mode_c = req_mode[2*i +: 2];
                sel_addr_c = req_addr[64*i +: 64];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        req_ack_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_ctrl_d  = rsp_ctrl_q;
        busy_d      = busy_q;
        cmode_d     = cmode_q;
        caddr_d     = caddr_q;
        cstart_d    = cstart_q;
`ifdef CHECKER_SCHED_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        wd_cnt_d      = wd_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    id_d      = win_c;
                    cmode_d   = sel_mode_c;
                    caddr_d   = sel_addr_c;
                    cstart_d  = 1'b1;
                    req_ack_d = NREQ'(1) << win_c;
                    rr_ptr_d  = win_c + ID_W'(1);
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
`ifdef CHECKER_SCHED_TIMEOUT_EN
                    wd_cnt_d  = '0;
`endif
                end
            end
            S_RUN: begin
                // A real completion always beats a simultaneous watchdog expiry.
                if (cend) begin
                    cstart_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_ctrl_d  = cctrl;
                    state_d     = S_DONE;
`ifdef CHECKER_SCHED_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
`ifdef CHECKER_SCHED_TIMEOUT_EN
                else if (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cstart_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = id_q;
                    rsp_ctrl_d    = 8'hFF;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
`endif
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d   = 1'b0;
                cstart_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            req_ack_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ctrl_q  <= '0;
            busy_q      <= 1'b0;
            cmode_q     <= '0;
            caddr_q     <= '0;
            cstart_q    <= 1'b0;
`ifdef CHECKER_SCHED_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            req_ack_q   <= req_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ctrl_q  <= rsp_ctrl_d;
            busy_q      <= busy_d;
            cmode_q     <= cmode_d;
            caddr_q     <= caddr_d;
            cstart_q    <= cstart_d;
`ifdef CHECKER_SCHED_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
`endif
        end
    end

    assign req_ack   = req_ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ctrl  = rsp_ctrl_q;
    assign busy      = busy_q;
    assign cmode     = cmode_q;
    assign caddr     = caddr_q;
    assign cstart    = cstart_q;
`ifdef CHECKER_SCHED_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_checker_sched.sv
// Directed + randomized bench for checker_sched with a transaction-level round-robin model.
module tb_checker_sched;

    localparam int unsigned ID_W = 2;
    localparam int unsigned NREQ = 4;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_mode;
    logic [64*NREQ-1:0]   req_addr;
    logic [NREQ-1:0]      req_ack;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_ctrl;
    logic                 rsp_timeout;
    logic                 busy;
    logic [1:0]           cmode;
    logic [63:0]          caddr;
    logic                 cstart;
    logic                 cend;
    logic [7:0]           cctrl;

    checker_sched #(.ID_W(ID_W), .TIMEOUT_CYCLES(8), .TO_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_addr(req_addr),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_ctrl(rsp_ctrl), .rsp_timeout(rsp_timeout), .busy(busy),
        .cmode(cmode), .caddr(caddr), .cstart(cstart),
        .cend(cend), .cctrl(cctrl)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int          ptr_m;
    logic [1:0]  mode_m [NREQ];
    logic [63:0] addr_m [NREQ];
    logic [1:0]  g_mode;
    logic [63:0] g_addr;
    logic [7:0]  last_ctrl;
    int          last_id;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] m, input logic [63:0] a);
        mode_m[i] = m;
        addr_m[i] = a;
        req_mode[2*i +: 2]  = m;
        req_addr[64*i +: 64] = a;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},    64'(req_ack), 64'd0);
        chk({tag, "_rspv"},   64'(rsp_valid), 64'd0);
        chk({tag, "_rspid"},  64'(rsp_id), 64'd0);
        chk({tag, "_rspctl"}, 64'(rsp_ctrl), 64'd0);
        chk({tag, "_rspto"},  64'(rsp_timeout), 64'd0);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_cmode"},  64'(cmode), 64'd0);
        chk({tag, "_caddr"},  caddr, 64'd0);
        chk({tag, "_cstart"}, 64'(cstart), 64'd0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        sys_rst   = 1'b0;
        ptr_m     = 0;
        last_ctrl = 8'h00;
        last_id   = 0;
    endtask

    // Edge with pending requests in IDLE: expect requester w granted.
    task automatic grant(input int w);
        step();
        g_mode = mode_m[w];
        g_addr = addr_m[w];
        chk("grant_ack",    64'(req_ack), 64'(1 << w));
        chk("grant_cstart", 64'(cstart), 64'd1);
        chk("grant_cmode",  64'(cmode), 64'(g_mode));
        chk("grant_caddr",  caddr, g_addr);
        chk("grant_busy",   64'(busy), 64'd1);
        chk("grant_rspv",   64'(rsp_valid), 64'd0);
        ptr_m = (w + 1) % NREQ;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            cend = 1'b0;
            step();
            chk("run_cstart", 64'(cstart), 64'd1);
            chk("run_ack",    64'(req_ack), 64'd0);
            chk("run_rspv",   64'(rsp_valid), 64'd0);
            chk("run_cmode",  64'(cmode), 64'(g_mode));
            chk("run_caddr",  caddr, g_addr);
        end
    endtask

    task automatic finish_job(input int w, input logic [7:0] ctl, input logic done_cend);
        cend  = 1'b1;
        cctrl = ctl;
        step();
        chk("end_rspv",   64'(rsp_valid), 64'd1);
        chk("end_rspid",  64'(rsp_id), 64'(w));
        chk("end_rspctl", 64'(rsp_ctrl), 64'(ctl));
        chk("end_rspto",  64'(rsp_timeout), 64'd0);
        chk("end_cstart", 64'(cstart), 64'd0);
        chk("end_busy",   64'(busy), 64'd1);
        last_ctrl = ctl;
        last_id   = w;
        cend = done_cend;
        step();
        chk("done_rspv",   64'(rsp_valid), 64'd0);
        chk("done_cstart", 64'(cstart), 64'd0);
        chk("done_busy",   64'(busy), 64'd0);
        chk("done_ack",    64'(req_ack), 64'd0);
        chk("done_rspctl", 64'(rsp_ctrl), 64'(last_ctrl));
        chk("done_rspid",  64'(rsp_id), 64'(last_id));
        cend = 1'b0;
    endtask

    initial begin
        int w;
        logic [NREQ-1:0] nv;
        req_valid = '0;
        req_mode  = '0;
        req_addr  = '0;
        cend      = 1'b0;
        cctrl     = 8'h00;
        sys_rst   = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 64'd0);

        // Reset state, then single job from requester 0
        step();
        do_reset();
        chk_zero("reset");
        set_req(0, 2'd2, 64'h1000);
        req_valid = 4'b0001;
        grant(0);
        req_valid = 4'b0000;
        run_cycles(3);
        finish_job(0, 8'h5A, 1'b0);
        step();
        chk("t1_idle_cstart", 64'(cstart), 64'd0);
        chk("t1_idle_ack",    64'(req_ack), 64'd0);

        // All four requesting continuously: strict rotation
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 64'hA0 + 64'(i));
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            grant(j % NREQ);
            run_cycles(1);
            finish_job(j % NREQ, 8'(8'h10 + j), 1'b0);
        end
        req_valid = 4'b0000;
        step();

        // Wrap-around from rr_ptr=2
        do_reset();
        req_valid = 4'b0010;
        grant(1);
        req_valid = 4'b0000;
        finish_job(1, 8'h21, 1'b0);
        req_valid = 4'b0011;
        grant(0);
        req_valid = 4'b0010;
        run_cycles(1);
        finish_job(0, 8'h22, 1'b0);
        req_valid = 4'b0011;
        grant(1);
        req_valid = 4'b0000;
        finish_job(1, 8'h23, 1'b1);

        // Stray cend in IDLE and on the grant edge
        cend  = 1'b1;
        cctrl = 8'hEE;
        step();
        chk("t4_idle_rspv",   64'(rsp_valid), 64'd0);
        chk("t4_idle_busy",   64'(busy), 64'd0);
        chk("t4_idle_cstart", 64'(cstart), 64'd0);
        chk("t4_idle_rspctl", 64'(rsp_ctrl), 64'(last_ctrl));
        req_valid = 4'b0100;
        w = pick(req_valid, ptr_m);
        grant(w);
        req_valid = 4'b0000;
        run_cycles(2);
        finish_job(w, 8'h44, 1'b1);

        // Reset in the middle of a run
        do_reset();
        req_valid = 4'b0100;
        grant(2);
        req_valid = 4'b0000;
        run_cycles(1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk_zero("t5_rst");
        cend  = 1'b1;
        cctrl = 8'h77;
        step();
        chk("t5_late_rspv", 64'(rsp_valid), 64'd0);
        chk("t5_late_busy", 64'(busy), 64'd0);
        chk("t5_late_ctl",  64'(rsp_ctrl), 64'd0);
        cend  = 1'b0;
        ptr_m = 0;
        req_valid = 4'b1010;
        grant(1);
        req_valid = 4'b0000;
        finish_job(1, 8'h31, 1'b0);

`ifdef CHECKER_SCHED_TIMEOUT_EN
        // Watchdog expiry, then cend exactly on the expiry edge
        req_valid = 4'b0001;
        w = pick(req_valid, ptr_m);
        grant(w);
        req_valid = 4'b0000;
        run_cycles(7);
        step();
        chk("to_rspv",   64'(rsp_valid), 64'd1);
        chk("to_flag",   64'(rsp_timeout), 64'd1);
        chk("to_rspctl", 64'(rsp_ctrl), 64'hFF);
        chk("to_rspid",  64'(rsp_id), 64'(w));
        chk("to_cstart", 64'(cstart), 64'd0);
        step();
        chk("to_done_busy", 64'(busy), 64'd0);
        chk("to_done_rspv", 64'(rsp_valid), 64'd0);
        req_valid = 4'b0001;
        w = pick(req_valid, ptr_m);
        grant(w);
        req_valid = 4'b0000;
        run_cycles(7);
        finish_job(w, 8'h33, 1'b0);
`else
        // Without the watchdog a long run simply waits
        req_valid = 4'b0001;
        w = pick(req_valid, ptr_m);
        grant(w);
        req_valid = 4'b0000;
        run_cycles(20);
        finish_job(w, 8'h33, 1'b0);
`endif

        // Randomized traffic against the round-robin model
        req_valid = '0;
        for (int job = 0; job < 40; job++) begin
            nv = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && nv[i])
                    set_req(i, 2'($urandom), {32'($urandom), 32'($urandom)});
            end
            req_valid = req_valid | nv;
            if (req_valid == '0) begin
                step();
                chk("rnd_idle_ack",    64'(req_ack), 64'd0);
                chk("rnd_idle_cstart", 64'(cstart), 64'd0);
                w = $urandom_range(0, NREQ - 1);
                set_req(w, 2'($urandom), {32'($urandom), 32'($urandom)});
                req_valid[w] = 1'b1;
            end
            w = pick(req_valid, ptr_m);
            grant(w);
            req_valid[w] = 1'b0;
            if ($urandom_range(0, 3) == 0) req_valid = req_valid & 4'($urandom);
            run_cycles($urandom_range(0, 5));
            finish_job(w, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
